// File: rtl/rsa_exp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rsa_exp_ctrl
// Purpose  : Sequencer for RSA modular exponentiation c = m^e mod p using
//            Montgomery left-to-right square-and-multiply. It drives a shared
//            Montgomery multiplier (mmul) through a start/done handshake. The
//            modulus p goes from the register wrapper straight to the
//            multiplier and does not pass through this block.
//
// Ports    : clk, rstb        clock, asynchronous active-low reset
//            ena              global enable; all state holds while low
//            start_cmd        start pulse, accepted in IDLE or DONE only
//            stop_cmd         abort pulse; wins over start_cmd
//            rsa_e/m/const    exponent, message, R^2 mod p (R = 2^WIDTH)
//            mmul_start       one-cycle request to the multiplier
//            mmul_a/mmul_b    registered operands, held until mmul_done
//            mmul_done        completion pulse, mmul_result valid with it
//            mmul_result      a*b*R^-1 mod p
//            rsa_c            registered result
//            irq              result-ready level
//            busy             high in every state except IDLE and DONE
//
// Revision : 1.0 - initial release
// ============================================================================
module rsa_exp_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             ena,
  input  logic             start_cmd,
  input  logic             stop_cmd,
  input  logic [WIDTH-1:0] rsa_e,
  input  logic [WIDTH-1:0] rsa_m,
  input  logic [WIDTH-1:0] rsa_const,
  output logic             mmul_start,
  output logic [WIDTH-1:0] mmul_a,
  output logic [WIDTH-1:0] mmul_b,
  input  logic             mmul_done,
  input  logic [WIDTH-1:0] mmul_result,
  output logic [WIDTH-1:0] rsa_c,
  output logic             irq,
  output logic             busy
);

  localparam int               IDXW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] c_one     = WIDTH'(1);
  localparam logic [IDXW-1:0]  c_idx_top = IDXW'(WIDTH - 1);
  localparam logic [IDXW-1:0]  c_idx_one = IDXW'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_PRE_M  = 3'd1,
    S_PRE_X  = 3'd2,
    S_SQUARE = 3'd3,
    S_MULT   = 3'd4,
    S_POST   = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_e, w_e_nxt;
  logic [WIDTH-1:0] r_const, w_const_nxt;
  logic [WIDTH-1:0] r_mbar, w_mbar_nxt;
  logic [IDXW-1:0]  r_idx, w_idx_nxt;
  logic             r_start, w_start_nxt;
  logic [WIDTH-1:0] r_a, w_a_nxt;
  logic [WIDTH-1:0] r_b, w_b_nxt;
  logic [WIDTH-1:0] r_c, w_c_nxt;
  logic             r_irq, w_irq_nxt;

  logic             w_op_state;
  logic             w_done_ok;
  logic             w_bit;
  logic             w_idx_zero;

  // The running value x is never kept in a separate register: every op that
  // consumes x takes it straight from mmul_result into the operand registers,
  // and the operand registers then hold it for the whole op. Likewise the
  // captured message lives in mmul_a for the duration of PRE_M.
  assign w_op_state = (r_state == S_PRE_M) || (r_state == S_PRE_X) ||
                      (r_state == S_SQUARE) || (r_state == S_MULT) ||
                      (r_state == S_POST);
  // A done pulse coinciding with our own start cycle cannot belong to the
  // op being issued, so it is masked.
  assign w_done_ok  = w_op_state && !r_start && mmul_done;
  assign w_bit      = r_e[r_idx];
  assign w_idx_zero = (r_idx == '0);

  always_comb begin
    w_state_nxt = r_state;
    w_e_nxt     = r_e;
    w_const_nxt = r_const;
    w_mbar_nxt  = r_mbar;
    w_idx_nxt   = r_idx;
    w_start_nxt = 1'b0;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    w_c_nxt     = r_c;
    w_irq_nxt   = r_irq;

    if (stop_cmd) begin
      // Abort from any state; an in-flight done is later ignored in IDLE.
      w_state_nxt = S_IDLE;
      w_irq_nxt   = 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start_cmd) begin
            w_e_nxt     = rsa_e;
            w_const_nxt = rsa_const;
            w_idx_nxt   = c_idx_top;
            w_irq_nxt   = 1'b0;
            w_state_nxt = S_PRE_M;
            w_start_nxt = 1'b1;
            w_a_nxt     = rsa_m;
            w_b_nxt     = rsa_const;
          end
        end

        S_PRE_M: begin
          // mbar = m*R mod p
          if (w_done_ok) begin
            w_mbar_nxt  = mmul_result;
            w_state_nxt = S_PRE_X;
            w_start_nxt = 1'b1;
            w_a_nxt     = c_one;
            w_b_nxt     = r_const;
          end
        end

        S_PRE_X: begin
          // x = R mod p, the Montgomery form of 1
          if (w_done_ok) begin
            w_state_nxt = S_SQUARE;
            w_start_nxt = 1'b1;
            w_a_nxt     = mmul_result;
            w_b_nxt     = mmul_result;
          end
        end

        S_SQUARE: begin
          if (w_done_ok) begin
            if (w_bit) begin
              w_state_nxt = S_MULT;
              w_start_nxt = 1'b1;
              w_a_nxt     = mmul_result;
              w_b_nxt     = r_mbar;
            end else if (w_idx_zero) begin
              w_state_nxt = S_POST;
              w_start_nxt = 1'b1;
              w_a_nxt     = mmul_result;
              w_b_nxt     = c_one;
            end else begin
              w_idx_nxt   = r_idx - c_idx_one;
              w_start_nxt = 1'b1;
              w_a_nxt     = mmul_result;
              w_b_nxt     = mmul_result;
            end
          end
        end

        S_MULT: begin
          if (w_done_ok) begin
            w_start_nxt = 1'b1;
            w_a_nxt     = mmul_result;
            if (w_idx_zero) begin
              w_state_nxt = S_POST;
              w_b_nxt     = c_one;
            end else begin
              w_idx_nxt   = r_idx - c_idx_one;
              w_state_nxt = S_SQUARE;
              w_b_nxt     = mmul_result;
            end
          end
        end

        S_POST: begin
          // Multiplying by 1 leaves Montgomery form.
          if (w_done_ok) begin
            w_c_nxt     = mmul_result;
            w_irq_nxt   = 1'b1;
            w_state_nxt = S_DONE;
          end
        end

        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state <= S_IDLE;
      r_e     <= '0;
      r_const <= '0;
      r_mbar  <= '0;
      r_idx   <= '0;
      r_start <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
      r_irq   <= 1'b0;
    end else if (ena) begin
      r_state <= w_state_nxt;
      r_e     <= w_e_nxt;
      r_const <= w_const_nxt;
      r_mbar  <= w_mbar_nxt;
      r_idx   <= w_idx_nxt;
      r_start <= w_start_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_c     <= w_c_nxt;
      r_irq   <= w_irq_nxt;
    end
  end

  assign mmul_start = r_start;
  assign mmul_a     = r_a;
  assign mmul_b     = r_b;
  assign rsa_c      = r_c;
  assign irq        = r_irq;
  assign busy       = (r_state != S_IDLE) && (r_state != S_DONE);

endmodule
`default_nettype wire
